// File: rtl/sa_north_feeder.sv
// sa_north_feeder: row-vector FIFO plus diagonal skew feeding the array's north edge.
// Optional per-column bias on north_result_in when SA_FEEDER_BIAS_EN is defined.
module sa_north_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int COLS = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [0:COLS-1],
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] north_data_in [0:COLS-1],
  output logic                  north_data_in_valid [0:COLS-1],
  output logic [DATA_WIDTH-1:0] north_result_in [0:COLS-1],
  output logic                  busy,
  output logic                  done
`ifdef SA_FEEDER_BIAS_EN
  ,
  input  logic                  bias_we,
  input  logic [DATA_WIDTH-1:0] bias_data [0:COLS-1]
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(COLS);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wp_q, rp_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH][COLS];
  logic [FIFO_DEPTH-1:0] last_q;
  logic [DATA_WIDTH-1:0] sd_q [COLS][COLS];
  logic [COLS-1:0] sv_q;
  logic done_q, empty, full, push, pop, pop_last;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign in_ready = !full && !rst;
  assign push = in_valid && in_ready;
  assign pop = (state_q != DRAIN) && !empty;
  assign pop_last = last_q[rp_q[AW-1:0]];
  assign busy = (state_q != IDLE) || !empty;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q[AW-1:0]] <= in_data;
      last_q[wp_q[AW-1:0]] <= in_last;
    end
  end
  // Stage k holds the whole vector; column c taps stage c, giving c cycles of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      done_q <= 1'b0;
      sv_q <= '0;
      for (int k = 0; k < COLS; k++)
        for (int c = 0; c < COLS; c++) sd_q[k][c] <= '0;
    end else begin
      wp_q <= wp_q + PW'(push);
      rp_q <= rp_q + PW'(pop);
      done_q <= (state_q == DRAIN) && (cnt_q == CW'(1));
      sv_q <= {sv_q[COLS-2:0], pop};
      for (int c = 0; c < COLS; c++) sd_q[0][c] <= pop ? mem_q[rp_q[AW-1:0]][c] : '0;
      for (int k = 1; k < COLS; k++) sd_q[k] <= sd_q[k-1];
      if (state_q == DRAIN) begin
        state_q <= (cnt_q == CW'(1)) ? IDLE : DRAIN;
        cnt_q <= cnt_q - CW'(1);
      end else if (pop) begin
        state_q <= pop_last ? DRAIN : STREAM;
        cnt_q <= CW'(COLS - 1);
      end
    end
  end
`ifdef SA_FEEDER_BIAS_EN
  logic [DATA_WIDTH-1:0] bias_q [COLS];
  logic [DATA_WIDTH-1:0] sb_q [COLS][COLS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) bias_q[c] <= '0;
      for (int k = 0; k < COLS; k++)
        for (int c = 0; c < COLS; c++) sb_q[k][c] <= '0;
    end else begin
      if (bias_we) bias_q <= bias_data;
      for (int c = 0; c < COLS; c++) sb_q[0][c] <= pop ? bias_q[c] : '0;
      for (int k = 1; k < COLS; k++) sb_q[k] <= sb_q[k-1];
    end
  end
`endif
  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign north_data_in[c] = sd_q[c][c];
    assign north_data_in_valid[c] = sv_q[c];
`ifdef SA_FEEDER_BIAS_EN
    assign north_result_in[c] = sb_q[c][c];
`else
    assign north_result_in[c] = '0;
`endif
  end
endmodule

// File: tb/tb_sa_north_feeder.sv
// tb_sa_north_feeder: directed bench; every cycle compares all columns and done
// against a table of hand-computed pop edges.
module tb_sa_north_feeder;
  localparam int DW = 16;
  localparam int C = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready, busy, done;
  logic [DW-1:0] in_data [0:C-1];
  logic [DW-1:0] north_data_in [0:C-1];
  logic north_data_in_valid [0:C-1];
  logic [DW-1:0] north_result_in [0:C-1];
`ifdef SA_FEEDER_BIAS_EN
  logic bias_we = 1'b0;
  logic [DW-1:0] bias_data [0:C-1];
`endif
  int ecnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  int cur_bias = 0;
  int exp_p[$], exp_b[$], exp_r[$], exp_dn[$];
  int e, a;

  sa_north_feeder #(.DATA_WIDTH(DW), .COLS(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .north_data_in(north_data_in), .north_data_in_valid(north_data_in_valid),
    .north_result_in(north_result_in), .busy(busy), .done(done)
`ifdef SA_FEEDER_BIAS_EN
    , .bias_we(bias_we), .bias_data(bias_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Column c in the cycle after edge ecnt shows the vector popped at edge ecnt-c.
  task automatic check_out();
    int dn;
    for (int c = 0; c < C; c++) begin
      int k;
      int xd;
      int xr;
      k = -1;
      xd = 0;
      xr = 0;
      foreach (exp_p[i]) if (exp_p[i] == ecnt - c) k = i;
      if (k >= 0) begin
        xd = exp_b[k] + c;
        xr = (exp_r[k] != 0) ? exp_r[k] + c : 0;
      end
      chk($sformatf("valid[%0d]@%0d", c, ecnt), north_data_in_valid[c], k >= 0);
      chk($sformatf("data[%0d]@%0d", c, ecnt), north_data_in[c], xd);
      chk($sformatf("result[%0d]@%0d", c, ecnt), north_result_in[c], xr);
    end
    dn = 0;
    foreach (exp_dn[i]) if (exp_dn[i] == ecnt) dn = 1;
    chk($sformatf("done@%0d", ecnt), done, dn);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic add(input int p, input int b);
    exp_p.push_back(p);
    exp_b.push_back(b);
    exp_r.push_back(cur_bias);
  endtask

  task automatic push(input int base, input logic last, output int acc);
    logic r;
    in_valid = 1'b1;
    in_last = last;
    for (int c = 0; c < C; c++) in_data[c] = DW'(base + c);
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      r = in_ready;
      step();
      if (r) acc = ecnt;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int c = 0; c < C; c++) in_data[c] = '0;
    if (acc < 0) chk($sformatf("push_timeout %0h", base), 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < C; c++) in_data[c] = '0;
`ifdef SA_FEEDER_BIAS_EN
    for (int c = 0; c < C; c++) bias_data[c] = '0;
`endif
    step();
    chk("ready_in_rst", in_ready, 0);
    chk("busy_rst", busy, 0);
    step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", in_ready, 1);
    chk("busy_idle", busy, 0);
    // single vector with last
    push(1, 1'b1, e);
    add(e + 1, 1);
    exp_dn.push_back(e + 8);
    chk("busy_s1", busy, 1);
    repeat (9) step();
    chk("busy_after_done", busy, 0);
    // burst 2 queued while burst 1 drains
    push('h100, 1'b1, e);
    add(e + 1, 'h100);
    exp_dn.push_back(e + 8);
    for (int i = 0; i < 5; i++) add(e + 9 + i, 'h200 + i * 16);
    exp_dn.push_back(e + 20);
    for (int i = 0; i < 4; i++) begin
      push('h200 + i * 16, 1'b0, a);
      chk($sformatf("acc_y%0d", i), a, e + 1 + i);
    end
    chk("ready_full", in_ready, 0);
    push('h240, 1'b1, a);
    chk("acc_y4", a, e + 10);
    chk("ready_reopen", in_ready, 1);
    repeat (12) step();
    chk("busy_s2", busy, 0);
    // A, two-cycle gap, B(last)
    push('h300, 1'b0, e);
    add(e + 1, 'h300);
    step();
    step();
    push('h400, 1'b1, a);
    chk("acc_b", a, e + 3);
    add(e + 4, 'h400);
    exp_dn.push_back(e + 11);
    repeat (12) step();
    // reset with three vectors in flight
    push('h500, 1'b0, e);
    add(e + 1, 'h500);
    push('h510, 1'b0, a);
    add(e + 2, 'h510);
    push('h520, 1'b1, a);
    add(e + 3, 'h520);
    exp_dn.push_back(e + 10);
    step();
    rst = 1'b1;
    #1;
    chk("ready_mid_rst", in_ready, 0);
    exp_p.delete();
    exp_b.delete();
    exp_r.delete();
    exp_dn.delete();
    step();
    rst = 1'b0;
    step();
    chk("ready_post_rst", in_ready, 1);
    chk("busy_post_rst", busy, 0);
    repeat (10) step();
    push('h600, 1'b1, e);
    add(e + 1, 'h600);
    exp_dn.push_back(e + 8);
    repeat (10) step();
`ifdef SA_FEEDER_BIAS_EN
    bias_we = 1'b1;
    for (int c = 0; c < C; c++) bias_data[c] = DW'(100 + c);
    step();
    bias_we = 1'b0;
    cur_bias = 100;
    push('h700, 1'b1, e);
    add(e + 1, 'h700);
    exp_dn.push_back(e + 8);
    repeat (10) step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_north_feeder.md
# sa_north_feeder

North-edge transmitter for the 8x8 spatial array. It accepts full row vectors (one element per column) on a valid/ready stream and buffers them in a small FIFO. It drives the array's `north_data_in` / `north_data_in_valid` / `north_result_in` lanes with the diagonal skew the array needs: column c lags column 0 by c cycles. It sits between the operand fetch logic and row 0 of the array; the array has no backpressure, so the feeder free-runs once a burst starts.

## Interface
- `DATA_WIDTH`, 16, element width
- `COLS`, 8, array columns; must be ≥ 2
- `FIFO_DEPTH`, 4, vector FIFO entries; power of two, ≥ 2
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: input vector valid
- `in_ready` out 1: FIFO can accept; `!full && !rst`; does not depend on `in_valid`
- `in_data[0:COLS-1]` in DATA_WIDTH each: row vector; element c goes to column c
- `in_last` in 1: marks the final vector of a burst
- `north_data_in[0:COLS-1]` out DATA_WIDTH each: to array row 0
- `north_data_in_valid[0:COLS-1]` out 1 each: to array row 0
- `north_result_in[0:COLS-1]` out DATA_WIDTH each: initial partial sum to array row 0
- `busy` out 1: state ≠ IDLE or FIFO non-empty
- `done` out 1: one-cycle pulse when a burst's last vector reaches column COLS-1
- `bias_we` in 1, `bias_data[0:COLS-1]` in DATA_WIDTH each: present only with `SA_FEEDER_BIAS_EN`

## Operation
- The FIFO stores {data vector, last}. A push occurs on `in_valid && in_ready`.
  - No bypass: a vector pushed at edge E can pop at E+1 at the earliest.
  - A push while full is impossible, because `in_ready` is low. A pop on the same edge does not reopen the FIFO for that edge.
- The skew stage is a per-column delay line. Column c has c register stages after a shared column-0 output register.
  - Each column carries {data, valid}.
  - A bubble entry has valid=0 and data=0. Outputs are 0 whenever valid is 0.
- FSM:
  - **IDLE**: if the FIFO is non-empty, pop into the skew stage and go to STREAM. If the popped entry has last=1, go directly to DRAIN instead. Otherwise shift a bubble into the skew stage.
  - **STREAM**: if the FIFO is non-empty, pop. If it is empty, inject a bubble; the skew stays aligned and the gap propagates diagonally. A popped entry with last=1 loads `drain_cnt = COLS-1` and moves to DRAIN.
  - **DRAIN**: no pops; inject bubbles. The FIFO may still accept pushes. When `drain_cnt == 1`, go to IDLE and register `done=1` for one cycle. Otherwise decrement `drain_cnt`.
- The skew stage shifts every cycle in every state.
- Reset mid-operation: clears the FIFO, skew stage, FSM and `drain_cnt`. No `done` pulse is produced, and partially skewed data is discarded.

## Timing
- Reset values: all `north_*` outputs 0, all valids 0, `done` 0, `busy` 0. `in_ready` is 0 while `rst` is high and 1 on the first cycle after reset.
- Latency: a vector popped at edge P appears on column c during the cycle after edge P+c.
  - If the FIFO was empty at acceptance edge E, then P = E+1.
- `done` is high during the same cycle that column COLS-1 presents the last vector, i.e. after edge P_last+COLS-1.
- A new burst pops no earlier than the edge after the `done` cycle begins. The earliest pop is P_last+COLS, so column 0 goes valid in the cycle after edge P_last+COLS.
- Sustained throughput is one vector per cycle while the FIFO is non-empty in STREAM.

## Configuration
- `SA_FEEDER_BIAS_EN` defined:
  - A per-column bias register, reset 0, is loaded from `bias_data` on any edge with `bias_we`.
  - `north_result_in[c]` = bias[c] while column c is valid, else 0. It is skewed identically to the data.
  - A `bias_we` during a burst takes effect for vectors popped after the write edge.
- `SA_FEEDER_BIAS_EN` undefined: the `bias_*` ports are absent and `north_result_in` is constant 0.

## Test plan
- Single vector, in_data[c]=c+1, last=1, pushed at edge 0 → column c shows c+1 with valid=1 only in the cycle after edge 1+c. `done` is high in the cycle after edge 8; `busy` is low afterwards.
- Five vectors presented back-to-back while the FSM is held in DRAIN from a prior burst → `in_ready` falls after the 4th push. The 5th is accepted the cycle after the first pop. All five exit unskewed-consecutive on column 0.
- Vectors A, gap of 2 cycles, B(last) → column c shows A, two zero/invalid cycles, then B, each shifted by c cycles. There is one `done`, aligned with B on column 7.
- `rst` asserted for 1 cycle while 3 vectors are in flight → all outputs 0 on the next cycle, no `done`, `in_ready`=1 afterwards. A fresh single-vector burst then behaves as in the first scenario.
- `SA_FEEDER_BIAS_EN`: bias_data[c]=100+c written, then one vector with last → `north_result_in[c]`=100+c exactly when column c is valid, 0 otherwise.
- Burst 2 pushed during burst 1's DRAIN → the first pop of burst 2 happens exactly at edge P_last+COLS, with no overlap with burst 1 on column 7.
